// File: rtl/mesh_pkg.sv
// Shared mesh definitions: packet field positions, coordinate width, edge FSM states.
package mesh_pkg;

  localparam int unsigned PKT_W         = 64;
  localparam int unsigned COORD_W       = 4;

  localparam int unsigned PKT_VC        = 63;
  localparam int unsigned PKT_RSVD_HI   = 62;
  localparam int unsigned PKT_RSVD_LO   = 56;
  localparam int unsigned PKT_SRC_X_HI  = 55;
  localparam int unsigned PKT_SRC_X_LO  = 52;
  localparam int unsigned PKT_SRC_Y_HI  = 51;
  localparam int unsigned PKT_SRC_Y_LO  = 48;
  localparam int unsigned PKT_DST_X_HI  = 47;
  localparam int unsigned PKT_DST_X_LO  = 44;
  localparam int unsigned PKT_DST_Y_HI  = 43;
  localparam int unsigned PKT_DST_Y_LO  = 40;
  localparam int unsigned PKT_PAY_HI    = 39;
  localparam int unsigned PKT_PAY_LO    = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } edge_state_e;

  // Send a packet back where it came from: old source becomes destination,
  // this endpoint becomes source; vc, rsvd and payload pass through.
  function automatic logic [PKT_W-1:0] reflect_pkt(input logic [PKT_W-1:0] pkt,
                                                   input logic [COORD_W-1:0] my_x,
                                                   input logic [COORD_W-1:0] my_y);
    logic [PKT_W-1:0] r;
    r = pkt;
    r[PKT_SRC_X_HI:PKT_SRC_X_LO] = my_x;
    r[PKT_SRC_Y_HI:PKT_SRC_Y_LO] = my_y;
    r[PKT_DST_X_HI:PKT_DST_X_LO] = pkt[PKT_SRC_X_HI:PKT_SRC_X_LO];
    r[PKT_DST_Y_HI:PKT_DST_Y_LO] = pkt[PKT_SRC_Y_HI:PKT_SRC_Y_LO];
    return r;
  endfunction

endpackage

// File: rtl/edge_fifo.sv
// Synchronous DEPTH x W FIFO with wrapping pointers and a separate occupancy count.
module edge_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/mesh_edge_reflector.sv
// Edge endpoint: accepts off-edge packets, optionally reflects them back into the mesh.
module mesh_edge_reflector
  import mesh_pkg::*;
#(
  parameter int unsigned        DEPTH = 4,
  parameter int unsigned        AW    = 2,
  parameter logic [COORD_W-1:0] MY_X  = 4'd0,
  parameter logic [COORD_W-1:0] MY_Y  = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             snso,
  input  logic [PKT_W-1:0] sndo,
  output logic             snro,
  output logic             nssi,
  output logic [PKT_W-1:0] nsdi,
  input  logic             nsri,
  input  logic             mode,
  input  logic             flush,
  output logic             busy,
  output logic [15:0]      rx_cnt,
  output logic [15:0]      tx_cnt
);

  localparam int unsigned CW = AW + 1;

  edge_state_e      state_q, state_d;
  logic             snro_q, snro_d;
  logic             nssi_q, nssi_d;
  logic             busy_q, busy_d;
  logic [15:0]      rx_cnt_q, rx_cnt_d;
  logic [15:0]      tx_cnt_q, tx_cnt_d;
  logic [CW-1:0]    count_d;

  logic             accept;
  logic             push_fifo;
  logic             pop;
  logic [PKT_W-1:0] head;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  assign accept    = snso && snro_q && !full;
  assign push_fifo = accept && !mode;
  assign pop       = nssi_q && nsri;

  edge_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_fifo),
    .pop_i   (pop),
    .din_i   (reflect_pkt(sndo, MY_X, MY_Y)),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Next-state: RUN/DRAIN transitions and look-ahead of the registered handshake outputs.
  always_comb begin
    state_d  = state_q;
    count_d  = count + CW'(push_fifo) - CW'(pop);
    rx_cnt_d = rx_cnt_q + 16'(accept);
    tx_cnt_d = tx_cnt_q + 16'(pop);
    if (state_q == ST_RUN) begin
      if (flush) state_d = ST_DRAIN;
    end else begin
      if ((count == '0) && !flush) state_d = ST_RUN;
    end
    snro_d = (state_d == ST_RUN) && (count_d < CW'(DEPTH));
    nssi_d = (count_d != '0);
    busy_d = nssi_d || (state_d == ST_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      snro_q   <= 1'b0;
      nssi_q   <= 1'b0;
      busy_q   <= 1'b0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      snro_q   <= snro_d;
      nssi_q   <= nssi_d;
      busy_q   <= busy_d;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign snro   = snro_q;
  assign nssi   = nssi_q;
  assign nsdi   = empty ? '0 : head;
  assign busy   = busy_q;
  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;

endmodule

// File: tb/tb_mesh_edge_reflector.sv
// Directed bench for mesh_edge_reflector with a queue-based reference model.
`timescale 1ns/1ps
module tb_mesh_edge_reflector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        snso = 1'b0;
  logic [63:0] sndo = '0;
  logic        nsri = 1'b0;
  logic        mode = 1'b0;
  logic        flush = 1'b0;
  logic        snro, nssi, busy;
  logic [63:0] nsdi;
  logic [15:0] rx_cnt, tx_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mesh_edge_reflector dut (
    .clk    (clk),
    .reset  (reset),
    .snso   (snso),
    .sndo   (sndo),
    .snro   (snro),
    .nssi   (nssi),
    .nsdi   (nsdi),
    .nsri   (nsri),
    .mode   (mode),
    .flush  (flush),
    .busy   (busy),
    .rx_cnt (rx_cnt),
    .tx_cnt (tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected reflected packet, built by field concatenation.
  function automatic logic [63:0] refl(input logic [63:0] p);
    return {p[63:56], 4'h0, 4'hF, p[55:48], p[39:0]};
  endfunction

  function automatic logic [63:0] mk(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b[0], 7'(i >> 1), b[3:0], b[7:4] ^ 4'h9, 4'hA, 4'h5, 8'hC3, b, 24'(i * 977)};
  endfunction

  // Reference model: queue of packets awaiting injection plus RUN/DRAIN flag.
  logic [63:0] mq[$];
  bit          m_drain;
  bit          m_snro;
  logic [15:0] m_rx, m_tx;

  always @(posedge clk) begin
    int  n0;
    bit  acc;
    bit  nd;
    if (reset) begin
      mq.delete();
      m_drain <= 1'b0;
      m_snro  <= 1'b0;
      m_rx    <= '0;
      m_tx    <= '0;
    end else begin
      n0  = mq.size();
      acc = snso && m_snro;
      if (n0 != 0 && nsri) begin
        void'(mq.pop_front());
        m_tx <= m_tx + 16'd1;
      end
      if (acc) begin
        m_rx <= m_rx + 16'd1;
        if (!mode) mq.push_back(refl(sndo));
      end
      nd = m_drain;
      if (!m_drain && flush) nd = 1'b1;
      else if (m_drain && n0 == 0 && !flush) nd = 1'b0;
      m_drain <= nd;
      m_snro  <= !nd && (mq.size() < 4);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("snro", 64'(snro), 64'(m_snro));
      chk("nssi", 64'(nssi), 64'(mq.size() != 0));
      chk("nsdi", nsdi, (mq.size() != 0) ? mq[0] : 64'h0);
      chk("busy", 64'(busy), 64'((mq.size() != 0) || m_drain));
      chk("rx_cnt", 64'(rx_cnt), 64'(m_rx));
      chk("tx_cnt", 64'(tx_cnt), 64'(m_tx));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (nssi && n < max) begin
      step(1);
      n++;
    end
    chk("drain_timeout", 64'(nssi), 64'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    reset = 1'b1;
    step(5);
    chk_en = 1'b1;
    chk("rst_snro", 64'(snro), 64'h0);
    chk("rst_nssi", 64'(nssi), 64'h0);
    chk("rst_nsdi", nsdi, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rx", 64'(rx_cnt), 64'h0);
    chk("rst_tx", 64'(tx_cnt), 64'h0);
    reset = 1'b0;
    step(1);
    chk("run_snro", 64'(snro), 64'h1);

    // 1. Reflect one packet
    mode = 1'b0; nsri = 1'b1;
    snso = 1'b1; sndo = 64'h0012_3000_0000_00AB;
    step(1);
    snso = 1'b0;
    chk("t1_nssi", 64'(nssi), 64'h1);
    chk("t1_nsdi", nsdi, 64'h000F_1200_0000_00AB);
    chk("t1_rx", 64'(rx_cnt), 64'h1);
    step(1);
    chk("t1_tx", 64'(tx_cnt), 64'h1);
    chk("t1_empty", 64'(nssi), 64'h0);

    // 2. Backpressure, full, held 5th packet
    nsri = 1'b0;
    for (int i = 0; i < 4; i++) begin
      snso = 1'b1; sndo = mk(i);
      step(1);
    end
    chk("t2_full_snro", 64'(snro), 64'h0);
    sndo = mk(4);
    step(2);
    chk("t2_held_rx", 64'(rx_cnt), 64'd5);
    chk("t2_head", nsdi, refl(mk(0)));
    nsri = 1'b1;
    step(1);
    chk("t2_snro_back", 64'(snro), 64'h1);
    chk("t2_second", nsdi, refl(mk(1)));
    step(1);
    snso = 1'b0;
    wait_empty(20);
    chk("t2_rx", 64'(rx_cnt), 64'd6);
    chk("t2_tx", 64'(tx_cnt), 64'd6);

    // 3. Simultaneous push/pop at count 2
    nsri = 1'b0;
    snso = 1'b1; sndo = mk(10); step(1);
    sndo = mk(11); step(1);
    nsri = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sndo = mk(20 + i);
      step(1);
      chk("t3_nssi", 64'(nssi), 64'h1);
      chk("t3_snro", 64'(snro), 64'h1);
    end
    snso = 1'b0;
    wait_empty(20);
    chk("t3_tx", 64'(tx_cnt), 64'd18);

    // 4. Sink mode from a clean reset
    reset = 1'b1; step(1); reset = 1'b0; step(1);
    mode = 1'b1; nsri = 1'b1;
    for (int i = 0; i < 3; i++) begin
      snso = 1'b1; sndo = mk(30 + i);
      step(1);
      chk("t4_nssi", 64'(nssi), 64'h0);
    end
    snso = 1'b0;
    step(2);
    chk("t4_rx", 64'(rx_cnt), 64'd3);
    chk("t4_tx", 64'(tx_cnt), 64'd0);

    // 5. Flush with an accept on the same edge
    mode = 1'b0; nsri = 1'b0;
    snso = 1'b1; sndo = mk(40); step(1);
    sndo = mk(41); step(1);
    sndo = mk(42); flush = 1'b1; step(1);
    snso = 1'b0;
    chk("t5_snro", 64'(snro), 64'h0);
    chk("t5_busy", 64'(busy), 64'h1);
    chk("t5_rx", 64'(rx_cnt), 64'd6);
    step(2);
    chk("t5_hold", nsdi, refl(mk(40)));
    nsri = 1'b1; flush = 1'b0;
    wait_empty(20);
    step(1);
    chk("t5_run_snro", 64'(snro), 64'h1);
    chk("t5_idle_busy", 64'(busy), 64'h0);
    chk("t5_tx", 64'(tx_cnt), 64'd3);

    // 6. Reset mid-operation, then counter wrap
    nsri = 1'b0;
    snso = 1'b1; sndo = mk(50); step(1);
    sndo = mk(51); step(1);
    snso = 1'b0;
    chk("t6_nssi_pre", 64'(nssi), 64'h1);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("t6_nssi", 64'(nssi), 64'h0);
    chk("t6_rx", 64'(rx_cnt), 64'h0);
    chk("t6_tx", 64'(tx_cnt), 64'h0);
    nsri = 1'b1;
    step(3);
    chk("t6_no_stale", 64'(nssi), 64'h0);
    mode = 1'b1; snso = 1'b1; sndo = mk(60);
    step(65535);
    chk("t6_rx_max", 64'(rx_cnt), 64'hFFFF);
    step(1);
    chk("t6_rx_wrap", 64'(rx_cnt), 64'h0);
    snso = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_edge_reflector.md
Name: mesh_edge_reflector

Overview:
Boundary endpoint attached to one edge port of a mesh row, for example the south side of node (x,0).
- Acts as the far end of the router's edge handshake: it receives packets the mesh sends off-edge (snso/sndo, answered with snro).
- It injects packets back into the mesh (nssi/nsdi, answered with nsri).
- Received packets are buffered in a FIFO and, in reflect mode, returned with source and destination swapped.
- Used as a self-checking traffic partner for mesh-row benches and as a loopback terminator in silicon.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
AW, 2, log2(DEPTH).
MY_X, 4'd0, x coordinate written as source on reflected packets.
MY_Y, 4'hF, y coordinate written as source (the off-edge position).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high.
snso  in  1  mesh-to-edge valid.
sndo  in  64  mesh-to-edge packet.
snro  out  1  edge ready to accept.
nssi  out  1  edge-to-mesh valid.
nsdi  out  64  edge-to-mesh packet.
nsri  in  1  mesh ready to accept.
mode  in  1  0 = reflect, 1 = sink (consume and discard).
flush  in  1  level request: stop accepting and drain the FIFO.
busy  out  1  FIFO non-empty or state is DRAIN.
rx_cnt  out  16  packets accepted; wraps at 16'hFFFF to 0.
tx_cnt  out  16  packets injected; wraps.

Behaviour:
Reset values:
- snro=0, nssi=0, nsdi=0, busy=0, rx_cnt=0, tx_cnt=0.
- FIFO pointers 0, count 0, state RUN.
- Reset asserted mid-transfer discards all buffered packets, with no partial injection afterwards.

Packet format:
- [63] vc, [62:56] rsvd.
- [55:52] src_x, [51:48] src_y.
- [47:44] dst_x, [43:40] dst_y.
- [39:0] payload.

Accept rule:
- A transfer occurs on a posedge where snso && snro.
- snro = (state==RUN) && (count<DEPTH), computed from registered state only.
- Therefore snro is 0 when full, even if a pop happens in the same cycle.

Push path:
- On accept, rx_cnt increments.
- If mode==0, the FIFO stores the rewritten packet:
  - vc kept, rsvd kept, payload kept.
  - src := {MY_X, MY_Y}.
  - dst := the received src.
- If mode==1, the packet is dropped and only rx_cnt changes.

Inject rule:
- nssi = count!=0; nsdi = FIFO head. Both are driven from registers or RAM with no combinational path from nsri.
- A transfer occurs on a posedge where nssi && nsri; the head pops and tx_cnt increments.
- While nssi=1 and nsri=0, nsdi holds stable.
- nsdi is 0 when empty.

Latency:
- A packet accepted at edge N is visible on nssi/nsdi after edge N, i.e. in cycle N+1, provided the FIFO was empty.

Simultaneous events:
- Push and pop on the same edge leave count unchanged; both pointers advance modulo DEPTH.

Pointer wrap:
- AW-bit pointers with a separate count of AW+1 bits.

State machine:
- RUN: if flush=1, go to DRAIN next edge. The accept in the same cycle is still honoured, since snro was already 1.
- DRAIN: snro=0 and injection continues. When count==0 and flush==0, return to RUN. If flush is still high with the FIFO empty, stay in DRAIN.

Mode changes:
- Take effect from the next accept; packets already buffered are still injected.

Decomposition:
Shared package mesh_pkg:
- Packet field bit positions (PKT_VC, PKT_SRC_X_HI, etc.).
- Coordinate width.
- Localparams ST_RUN and ST_DRAIN.

Sub-module:
- One is natural: edge_fifo, a synchronous DEPTH x 64 FIFO with push, pop, head, count, full and empty.
- It is reused by future edge injectors.

Test Plan:
1. Reflect: reset 5 cycles, then mode=0, nsri=1, one packet sndo=64'h0012_3000_0000_00AB (src=(1,2), dst=(3,0)) -> next cycle nssi=1, nsdi=64'h000F_1200_0000_00AB; rx_cnt=1, tx_cnt=1 after the handshake.
2. Backpressure and full: nsri=0, push 4 packets -> snro drops to 0 after the 4th accept; a 5th snso is held. Release nsri -> packets emerge in order and snro returns to 1 one cycle after the first pop.
3. Simultaneous push/pop at count=2 for 10 consecutive cycles -> count stays 2, ordering preserved, pointers wrap.
4. Sink: mode=1, 3 packets -> rx_cnt=3, nssi never rises, tx_cnt=0.
5. Flush: 3 packets buffered, nsri=0, assert flush -> snro=0 the next cycle and busy=1. Then nsri=1 and deassert flush -> 3 injections, state RUN, busy=0, snro=1.
6. Reset mid-operation: 2 packets buffered and nssi=1, assert reset for 1 cycle -> nssi=0, counters 0, no stale packet after release. Also check counter wrap: preload 16'hFFFF via 65536 accepts -> rx_cnt=0.
